instr_ram_arbiter: RTL and testbench
====================================

# instr_ram_arbiter

Two-port arbiter placed in front of `instr_ram_wrap` that shares the single instruction memory port between the core instruction-fetch port and a loader/debug port. The loader port is AXI-bridged and is the only writer. The arbiter grants one request per cycle and drives the RAM-side enable, address and write controls. It tracks ownership of the one-cycle-latency read data and routes it back with an `rvalid` pulse to the requester that issued the access. It also rejects loader writes into the boot-ROM half of the address space.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: byte-word address width shared with `instr_ram_wrap`. The MSB selects the boot ROM.
- `STARVE_LIMIT`, 4: consecutive lost cycles after which the loader wins. Legal range is 1..15.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous reset, active-high.
- `fetch_req_i`, in, 1: core fetch request.
- `fetch_addr_i`, in, ADDR_WIDTH: fetch address.
- `fetch_gnt_o`, out, 1: fetch granted this cycle.
- `fetch_rvalid_o`, out, 1: fetch read data valid.
- `fetch_rdata_o`, out, 32: fetch read data.
- `ld_req_i`, in, 1: loader request.
- `ld_addr_i`, in, ADDR_WIDTH: loader address.
- `ld_we_i`, in, 1: loader write.
- `ld_be_i`, in, 4: loader byte enables.
- `ld_wdata_i`, in, 32: loader write data.
- `ld_gnt_o`, out, 1: loader granted this cycle.
- `ld_rvalid_o`, out, 1: loader response valid. Fires for both reads and writes.
- `ld_rdata_o`, out, 32: loader read data.
- `ld_err_o`, out, 1: loader response is an error. Qualified by `ld_rvalid_o`.
- `ram_en_o`, out, 1: to `instr_ram_wrap.en_i`.
- `ram_addr_o`, out, ADDR_WIDTH: to `addr_i`.
- `ram_we_o`, out, 1: to `we_i`.
- `ram_be_o`, out, 4: to `be_i`.
- `ram_wdata_o`, out, 32: to `wdata_i`.
- `ram_rdata_i`, in, 32: from `rdata_o`. Valid one cycle after `ram_en_o`.

## Operation
- **Grant logic:** combinational from the requests and the priority state. At most one `*_gnt_o` is high per cycle. A request with `gnt` low is held by the requester, with address and data stable, until granted.
- **Default priority:** fetch wins when both ports request.
- **Starvation counter `starve_cnt`:**
  - Increments on each cycle in which `ld_req_i` is high and the loader is not granted. Saturates at STARVE_LIMIT.
  - When `starve_cnt == STARVE_LIMIT`, the loader wins the next contention.
  - Clears on any loader grant.
- **RAM drive:** the granted port's address, we, be and wdata pass through combinationally. `ram_en_o` = any grant, except a suppressed write (below). When no port is granted, `ram_we_o` = 0 and `ram_be_o` = 0; `ram_addr_o` and `ram_wdata_o` hold the fetch values.
- **Fetch writes:** the fetch port never writes. `ram_we_o` is always 0 for fetch grants.
- **Boot-ROM write protection:** a loader write with `ld_addr_i[ADDR_WIDTH-1] == 1` is granted but `ram_en_o` is forced to 0. Its response is `ld_rvalid_o = 1` and `ld_err_o = 1` on the next cycle. Loader reads of the boot region are legal.
- **Response tracking:** two registered flags, `owner_q` (0 = fetch, 1 = loader) and `resp_q` (a response is due), plus `err_q`. All are set from the grant cycle.
- **Response routing:** in the response cycle, `ram_rdata_i` is routed to the owner's `rdata`. The non-owner's `rdata` is driven to 0. Loader write responses carry `ld_rdata_o` = 0.
- **State machine:** none beyond the flags above. The arbiter is fully pipelined, with one access per cycle and back-to-back grants to either port.

## Timing
- **Grant cycle N:** `gnt` is asserted in cycle N, the same cycle as `req`.
- **Response cycle N+1:** the matching `rvalid` pulses for exactly one cycle, with rdata valid in that cycle.
- **Throughput:** one response per grant, with no reordering.
- **Reset:**
  - While `rst` is high, both `gnt` outputs, `ram_en_o`, `ram_we_o`, `ram_be_o`, both `rvalid` outputs and `ld_err_o` are 0.
  - `ram_addr_o`, `ram_wdata_o` and both `rdata` outputs are also 0.
  - `starve_cnt`, `owner_q`, `resp_q` and `err_q` clear to 0.
- **Reset mid-operation:** an outstanding response is dropped and no `rvalid` is issued after reset. The first grant is possible in the cycle after `rst` falls.
- **Simultaneous events:** a new grant in the same cycle as the previous response is the normal case. The flags update from the new grant while the old response is delivered.
- **Counter saturation:** `starve_cnt` at STARVE_LIMIT does not wrap. It holds its value until the loader is granted.

## Configuration
- **`INSTR_ARB_FAIRNESS_EN` defined:** the starvation counter and the priority override are compiled in, as described above.
- **`INSTR_ARB_FAIRNESS_EN` undefined:** strict fixed priority to fetch. `starve_cnt` is not instantiated and `STARVE_LIMIT` is ignored. A permanently asserted `fetch_req_i` starves the loader indefinitely.

## Test plan
- **Reset hold:** hold `rst` for 3 cycles with both requests high. Required: all grants, `rvalid` outputs and `ram_en_o` stay 0. Then release `rst`; fetch is granted in the first cycle.
- **Single fetch read:** fetch reads 0x00010 with RAM returning 0xDEADBEEF. Required: `fetch_gnt_o` in cycle N and `fetch_rvalid_o` = 1 with `fetch_rdata_o` = 0xDEADBEEF in cycle N+1. `ld_rvalid_o` stays 0.
- **Loader write:** loader writes 0x00040, be = 4'b0011, data 0x12345678. Required: `ram_en_o`, `ram_we_o` and `ram_be_o` = 4'b0011 in the grant cycle. Next cycle `ld_rvalid_o` = 1 and `ld_err_o` = 0.
- **Boot-region write rejected:** loader writes 0x10000 (MSB set). Required: `ld_gnt_o` = 1 with `ram_en_o` = 0. Next cycle `ld_rvalid_o` = 1 and `ld_err_o` = 1.
- **Contention with fairness:** fetch and loader both request continuously with STARVE_LIMIT = 4 and `INSTR_ARB_FAIRNESS_EN` defined. Required: the loader is granted on every 5th cycle (4 fetch grants, then 1 loader grant). Each response is routed to the correct port with no lost or duplicated `rvalid`.
- **Contention without fairness:** the same stimulus with `INSTR_ARB_FAIRNESS_EN` undefined. Required: the loader is never granted while `fetch_req_i` is high, and is granted in the first cycle `fetch_req_i` drops.

Source files
------------

// File: rtl/instr_ram_arbiter.sv
// Shares the single instruction RAM port between core fetch and the loader/debug port.
// Optional fairness (starvation override for the loader) is enabled with `INSTR_ARB_FAIRNESS_EN.
module instr_ram_arbiter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_gnt_o,
  output logic                  fetch_rvalid_o,
  output logic [31:0]           fetch_rdata_o,
  input  logic                  ld_req_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic                  ld_we_i,
  input  logic [3:0]            ld_be_i,
  input  logic [31:0]           ld_wdata_i,
  output logic                  ld_gnt_o,
  output logic                  ld_rvalid_o,
  output logic [31:0]           ld_rdata_o,
  output logic                  ld_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  // Handshake: a requester raises req with stable address/data and holds it until gnt is
  // seen high in the same cycle; exactly one rvalid follows in the next cycle per grant.

  logic ld_prio;
  logic boot_wr;
  logic resp_q;
  logic owner_q;
  logic err_q;
  logic wr_q;

`ifdef INSTR_ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (ld_gnt_o) begin
      starve_cnt <= '0;
    end else if (ld_req_i && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign ld_prio = (starve_cnt == LIMIT);
`else
  logic unused_limit;
  assign unused_limit = ^STARVE_LIMIT;
  assign ld_prio      = 1'b0;
`endif

  assign ld_gnt_o    = !rst && ld_req_i && (!fetch_req_i || ld_prio);
  assign fetch_gnt_o = !rst && fetch_req_i && !ld_gnt_o;
  assign boot_wr     = ld_we_i && ld_addr_i[ADDR_WIDTH-1];

  // Rejected boot-ROM writes still take the grant slot so they get an error response.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = fetch_addr_i;
    ram_wdata_o = 32'h0;
    if (rst) begin
      ram_addr_o = '0;
    end else if (ld_gnt_o) begin
      ram_en_o    = !boot_wr;
      ram_we_o    = ld_we_i;
      ram_be_o    = ld_be_i;
      ram_addr_o  = ld_addr_i;
      ram_wdata_o = ld_wdata_i;
    end else if (fetch_gnt_o) begin
      ram_en_o = 1'b1;
      ram_be_o = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q  <= 1'b0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      resp_q  <= fetch_gnt_o || ld_gnt_o;
      owner_q <= ld_gnt_o;
      err_q   <= ld_gnt_o && boot_wr;
      wr_q    <= ld_gnt_o && ld_we_i;
    end
  end

  assign fetch_rvalid_o = !rst && resp_q && !owner_q;
  assign ld_rvalid_o    = !rst && resp_q && owner_q;
  assign ld_err_o       = ld_rvalid_o && err_q;
  assign fetch_rdata_o  = fetch_rvalid_o ? ram_rdata_i : 32'h0;
  assign ld_rdata_o     = (ld_rvalid_o && !wr_q) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Self-checking bench for instr_ram_arbiter: directed vector table, reset and contention
// sequences, then randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_instr_ram_arbiter;
  localparam int AW  = 17;
  localparam int LIM = 4;
`ifdef INSTR_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_we = 1'b0;
  logic [3:0]    ld_be = '0;
  logic [31:0]   ld_wdata = '0;
  logic          ld_gnt, ld_rvalid, ld_err;
  logic [31:0]   ld_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;

  instr_ram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_we_i(ld_we), .ld_be_i(ld_be),
    .ld_wdata_i(ld_wdata), .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid),
    .ld_rdata_o(ld_rdata), .ld_err_o(ld_err),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  // ---------------- records ----------------
  typedef struct packed {
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          l_req;
    logic [AW-1:0] l_addr;
    logic          l_we;
    logic [3:0]    l_be;
    logic [31:0]   l_wd;
    logic [31:0]   rram;
  } in_t;

  typedef struct packed {
    logic          f_gnt;
    logic          l_gnt;
    logic          en;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          f_rv;
    logic [31:0]   f_rd;
    logic          l_rv;
    logic [31:0]   l_rd;
    logic          l_err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Scoreboard: one tag per grant, {is_loader, is_error, is_write}, consumed next cycle.
  logic [2:0] exp_q[$];
  int         losses;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cmp_all(string tag, out_t e);
    chk({tag, ".fetch_gnt"},    32'(fetch_gnt),    32'(e.f_gnt));
    chk({tag, ".ld_gnt"},       32'(ld_gnt),       32'(e.l_gnt));
    chk({tag, ".ram_en"},       32'(ram_en),       32'(e.en));
    chk({tag, ".ram_we"},       32'(ram_we),       32'(e.we));
    chk({tag, ".ram_be"},       32'(ram_be),       32'(e.be));
    chk({tag, ".ram_addr"},     32'(ram_addr),     32'(e.addr));
    chk({tag, ".ram_wdata"},    ram_wdata,         e.wdata);
    chk({tag, ".fetch_rvalid"}, 32'(fetch_rvalid), 32'(e.f_rv));
    chk({tag, ".fetch_rdata"},  fetch_rdata,       e.f_rd);
    chk({tag, ".ld_rvalid"},    32'(ld_rvalid),    32'(e.l_rv));
    chk({tag, ".ld_rdata"},     ld_rdata,          e.l_rd);
    chk({tag, ".ld_err"},       32'(ld_err),       32'(e.l_err));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(in_t v);
    fetch_req  = v.f_req;
    fetch_addr = v.f_addr;
    ld_req     = v.l_req;
    ld_addr    = v.l_addr;
    ld_we      = v.l_we;
    ld_be      = v.l_be;
    ld_wdata   = v.l_wd;
    ram_rdata  = v.rram;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive('0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    losses = 0;
  endtask

  // Reference model: loader wins if fetch is idle, or (with fairness) after LIM lost cycles.
  task automatic model_step(string tag, output bit fg, output bit lg);
    out_t       e;
    logic [2:0] t;
    bit         boot;
    e    = '0;
    boot = ld_we && ld_addr[AW-1];
    lg   = ld_req && (!fetch_req || (FAIR && losses >= LIM));
    fg   = fetch_req && !lg;
    e.f_gnt = fg;
    e.l_gnt = lg;
    e.en    = fg || (lg && !boot);
    e.we    = lg && ld_we;
    e.be    = lg ? ld_be : (fg ? 4'hF : 4'h0);
    e.addr  = lg ? ld_addr : fetch_addr;
    e.wdata = lg ? ld_wdata : 32'h0;
    if (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      if (t[2]) begin
        e.l_rv  = 1'b1;
        e.l_err = t[1];
        e.l_rd  = t[0] ? 32'h0 : ram_rdata;
      end else begin
        e.f_rv = 1'b1;
        e.f_rd = ram_rdata;
      end
    end
    cmp_all(tag, e);
    if (lg) losses = 0;
    else if (ld_req && losses < LIM) losses++;
    if (fg || lg) exp_q.push_back({lg, lg && boot, lg && ld_we});
  endtask

  // ---------------- test ----------------
  vec_t vecs[12];
  bit   fg, lg;
  bit   f_pend, l_pend;

  initial begin
    vecs[0]  = '{i: '{1, 17'h10, 0, 17'h0, 0, 4'h0, 32'h0, 32'h0},
                 o: '{1, 0, 1, 0, 4'hF, 17'h10, 32'h0, 0, 32'h0, 0, 32'h0, 0}};
    vecs[1]  = '{i: '{0, 17'h0, 0, 17'h0, 0, 4'h0, 32'h0, 32'hDEADBEEF},
                 o: '{0, 0, 0, 0, 4'h0, 17'h0, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0, 0}};
    vecs[2]  = '{i: '{0, 17'h0, 1, 17'h40, 1, 4'b0011, 32'h12345678, 32'h0},
                 o: '{0, 1, 1, 1, 4'b0011, 17'h40, 32'h12345678, 0, 32'h0, 0, 32'h0, 0}};
    vecs[3]  = '{i: '{0, 17'h0, 0, 17'h0, 0, 4'h0, 32'h0, 32'hAAAA5555},
                 o: '{0, 0, 0, 0, 4'h0, 17'h0, 32'h0, 0, 32'h0, 1, 32'h0, 0}};
    vecs[4]  = '{i: '{0, 17'h0, 1, 17'h10000, 1, 4'hF, 32'h55, 32'h0},
                 o: '{0, 1, 0, 1, 4'hF, 17'h10000, 32'h55, 0, 32'h0, 0, 32'h0, 0}};
    vecs[5]  = '{i: '{0, 17'h0, 0, 17'h0, 0, 4'h0, 32'h0, 32'h77},
                 o: '{0, 0, 0, 0, 4'h0, 17'h0, 32'h0, 0, 32'h0, 1, 32'h0, 1}};
    vecs[6]  = '{i: '{0, 17'h0, 1, 17'h10008, 0, 4'hF, 32'h0, 32'h0},
                 o: '{0, 1, 1, 0, 4'hF, 17'h10008, 32'h0, 0, 32'h0, 0, 32'h0, 0}};
    vecs[7]  = '{i: '{1, 17'h20, 0, 17'h0, 0, 4'h0, 32'h0, 32'hCAFEF00D},
                 o: '{1, 0, 1, 0, 4'hF, 17'h20, 32'h0, 0, 32'h0, 1, 32'hCAFEF00D, 0}};
    vecs[8]  = '{i: '{0, 17'h0, 0, 17'h0, 0, 4'h0, 32'h0, 32'h01020304},
                 o: '{0, 0, 0, 0, 4'h0, 17'h0, 32'h0, 1, 32'h01020304, 0, 32'h0, 0}};
    vecs[9]  = '{i: '{1, 17'h30, 1, 17'h50, 0, 4'hF, 32'h0, 32'h0},
                 o: '{1, 0, 1, 0, 4'hF, 17'h30, 32'h0, 0, 32'h0, 0, 32'h0, 0}};
    vecs[10] = '{i: '{0, 17'h0, 1, 17'h50, 0, 4'hF, 32'h0, 32'h11112222},
                 o: '{0, 1, 1, 0, 4'hF, 17'h50, 32'h0, 1, 32'h11112222, 0, 32'h0, 0}};
    vecs[11] = '{i: '{0, 17'h0, 0, 17'h0, 0, 4'h0, 32'h0, 32'h33334444},
                 o: '{0, 0, 0, 0, 4'h0, 17'h0, 32'h0, 0, 32'h0, 1, 32'h33334444, 0}};

    // Reset hold with both ports requesting.
    @(posedge clk); #1;
    rst = 1'b1;
    drive('{1, 17'h123, 1, 17'h456, 1, 4'hF, 32'h9999AAAA, 32'h5A5A5A5A});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmp_all($sformatf("reset_hold%0d", c), '0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release.fetch_gnt", 32'(fetch_gnt), 32'd1);
    chk("reset_release.ld_gnt", 32'(ld_gnt), 32'd0);

    // Directed vector table.
    do_reset();
    for (int v = 0; v < 12; v++) begin
      @(posedge clk); #1;
      drive(vecs[v].i);
      @(negedge clk);
      cmp_all($sformatf("vec%0d", v), vecs[v].o);
    end

    // Reset mid-operation drops the outstanding response.
    @(posedge clk); #1;
    drive('{1, 17'h44, 0, 17'h0, 0, 4'h0, 32'h0, 32'h0});
    @(negedge clk);
    chk("midrst.grant", 32'(fetch_gnt), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive('{0, 17'h0, 0, 17'h0, 0, 4'h0, 32'h0, 32'hFEEDFACE});
    @(negedge clk);
    chk("midrst.rvalid_in_reset", 32'(fetch_rvalid), 32'd0);
    chk("midrst.rdata_in_reset", fetch_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.rvalid_after", 32'(fetch_rvalid), 32'd0);
    chk("midrst.ld_rvalid_after", 32'(ld_rvalid), 32'd0);

    // Continuous contention, then fetch drops.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      drive('{1, 17'h100, 1, 17'h200, 0, 4'hF, 32'h0, $urandom});
      @(negedge clk);
      chk($sformatf("contend%0d.pattern", c), 32'(ld_gnt),
          32'(FAIR && (c % 5 == 4)));
      model_step($sformatf("contend%0d", c), fg, lg);
    end
    @(posedge clk); #1;
    drive('{0, 17'h100, 1, 17'h200, 0, 4'hF, 32'h0, $urandom});
    @(negedge clk);
    chk("contend_release.ld_gnt", 32'(ld_gnt), 32'd1);
    model_step("contend_release", fg, lg);

    // Randomized traffic; each requester holds its request until granted.
    do_reset();
    f_pend = 1'b0;
    l_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!f_pend && ($urandom_range(0, 3) != 0)) begin
        f_pend     = 1'b1;
        fetch_addr = 17'($urandom_range(0, 131071));
      end
      if (!l_pend && ($urandom_range(0, 2) == 0)) begin
        l_pend   = 1'b1;
        ld_addr  = 17'($urandom_range(0, 131071));
        ld_we    = 1'($urandom_range(0, 1));
        ld_be    = 4'($urandom_range(0, 15));
        ld_wdata = $urandom;
      end
      fetch_req = f_pend;
      ld_req    = l_pend;
      ram_rdata = $urandom;
      @(negedge clk);
      model_step($sformatf("rand%0d", c), fg, lg);
      if (fg) f_pend = 1'b0;
      if (lg) l_pend = 1'b0;
    end
    @(posedge clk); #1;
    drive('{0, 17'h0, 0, 17'h0, 0, 4'h0, 32'h0, 32'h600DF00D});
    @(negedge clk);
    model_step("drain", fg, lg);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
